// File: rtl/plc_pkg.sv
// plc_pkg: timer mode codes and timer FSM state encoding shared by the PLC timer/counter bank
package plc_pkg;
    localparam logic [1:0] TMR_TON = 2'b00;
    localparam logic [1:0] TMR_TOF = 2'b01;
    localparam logic [1:0] TMR_TP  = 2'b10;
    typedef enum logic [1:0] {ST_IDLE, ST_HELD, ST_TIMING, ST_EXPIRED} tmr_state_t;
endpackage

// File: rtl/plc_channel.sv
// plc_channel: one start/stop latch, TON/TOF/TP timer and saturating event counter
module plc_channel import plc_pkg::*; #(
    parameter int TW = 16,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          tick,
    input  logic          start,
    input  logic          stop,
    input  logic          cnt_clr,
    input  logic [1:0]    mode,
    input  logic [TW-1:0] pt,
    input  logic [CW-1:0] cp,
    output logic          tmr_q,
    output logic          q,
    output logic [TW-1:0] et,
    output logic [CW-1:0] count
);
    tmr_state_t state, state_n;
    logic [1:0] mode_r, md;
    logic [TW-1:0] et_n;
    logic in_r, tq_d, is_tof, is_tp, done;
    // live mode while idle, frozen copy once the timer has left idle
    assign md = (state == ST_IDLE) ? mode : mode_r;
    assign is_tof = md == TMR_TOF;
    assign is_tp = md == TMR_TP;
    assign done = et >= pt;
    assign tmr_q = is_tof ? (state == ST_HELD || state == ST_TIMING) :
                   is_tp  ? (state == ST_TIMING) : (state == ST_EXPIRED);
    assign q = count >= cp;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            mode_r <= TMR_TON;
            et <= '0;
            in_r <= 1'b0;
            tq_d <= 1'b0;
            count <= '0;
        end else begin
            state <= state_n;
            mode_r <= md;
            et <= et_n;
            in_r <= start | (in_r & ~stop);
            tq_d <= tmr_q;
            if (cnt_clr)
                count <= '0;
            else if (tmr_q && !tq_d && !(&count))
                count <= count + 1'b1;
        end
    end
    always_comb begin
        state_n = state;
        et_n = et;
        case (state)
            ST_IDLE: if (in_r) state_n = is_tof ? ST_HELD : ST_TIMING;
            ST_HELD: if (!in_r) begin
                state_n = ST_TIMING;
                et_n = '0;
            end
            ST_TIMING: begin
                if (is_tof && in_r) begin
                    state_n = ST_HELD;
                    et_n = '0;
                end else if (!is_tof && !is_tp && !in_r) begin
                    state_n = ST_IDLE;
                    et_n = '0;
                end else if (done) begin
                    state_n = is_tof ? ST_IDLE : ST_EXPIRED;
                    et_n = is_tof ? '0 : et;
                end else if (tick) begin
                    et_n = et + 1'b1;
                end
            end
            ST_EXPIRED: if (!in_r) begin
                state_n = ST_IDLE;
                et_n = '0;
            end
            default: state_n = ST_IDLE;
        endcase
    end
endmodule

// File: rtl/plc_timer_counter_bank.sv
// plc_timer_counter_bank: shared time-base prescaler, NUM_CH timer/counter channels and AUTO/MAN control mux
module plc_timer_counter_bank import plc_pkg::*; #(
    parameter int NUM_CH   = 4,
    parameter int TW       = 16,
    parameter int CW       = 8,
    parameter int PRESCALE = 50000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_CH-1:0]    start,
    input  logic [NUM_CH-1:0]    stop,
    input  logic [2*NUM_CH-1:0]  mode,
    input  logic [TW*NUM_CH-1:0] tpreset,
    input  logic [CW*NUM_CH-1:0] cpreset,
    input  logic [NUM_CH-1:0]    cnt_clr,
    input  logic                 auto_mode,
    input  logic                 man_mode,
    output logic [NUM_CH-1:0]    ctrl,
    output logic [NUM_CH-1:0]    q,
    output logic [TW*NUM_CH-1:0] elapsed,
    output logic [CW*NUM_CH-1:0] count,
    output logic                 tick
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    logic [PW-1:0] pre;
    logic [NUM_CH-1:0] tmr_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pre <= '0;
        else
            pre <= tick ? '0 : pre + 1'b1;
    end
    assign tick = ~rst & (pre == PW'(PRESCALE - 1));
    assign ctrl = auto_mode ? tmr_q : man_mode ? start : '0;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        plc_channel #(.TW(TW), .CW(CW)) u_ch (
            .clk(clk),
            .rst(rst),
            .tick(tick),
            .start(start[i]),
            .stop(stop[i]),
            .cnt_clr(cnt_clr[i]),
            .mode(mode[i*2 +: 2]),
            .pt(tpreset[i*TW +: TW]),
            .cp(cpreset[i*CW +: CW]),
            .tmr_q(tmr_q[i]),
            .q(q[i]),
            .et(elapsed[i*TW +: TW]),
            .count(count[i*CW +: CW])
        );
    end
endmodule

// File: tb/tb_plc_timer_counter_bank.sv
// tb_plc_timer_counter_bank: directed stimulus with queued ctrl-edge and snapshot expectations
module tb_plc_timer_counter_bank;
    localparam int N = 4, TW = 8, CW = 4;
    localparam int ET = 0, CNT = 1, QV = 2, TK = 3;
    logic clk = 1'b0, rst = 1'b1;
    logic [N-1:0] start = '0, stop = '0, cnt_clr = '0;
    logic [2*N-1:0] mode = '0;
    logic [TW*N-1:0] tpreset;
    logic [CW*N-1:0] cpreset;
    logic auto_mode = 1'b1, man_mode = 1'b0;
    logic [N-1:0] ctrl, q;
    logic [TW*N-1:0] elapsed;
    logic [CW*N-1:0] count;
    logic tick;
    int cyc = 0, checks = 0, errors = 0;
    typedef struct { logic [3:0] c; int lo; int hi; bit rel; } ev_t;
    typedef struct { int at; int sel; int ch; int val; bit ge; } sn_t;
    ev_t evq[$];
    string evn[$];
    sn_t snq[$];
    string snn[$];

    plc_timer_counter_bank #(.NUM_CH(N), .TW(TW), .CW(CW), .PRESCALE(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode),
        .tpreset(tpreset), .cpreset(cpreset), .cnt_clr(cnt_clr),
        .auto_mode(auto_mode), .man_mode(man_mode), .ctrl(ctrl), .q(q),
        .elapsed(elapsed), .count(count), .tick(tick)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    // ctrl must change to c inside [lo,hi]; rel makes the window relative to the previous ctrl change
    task automatic expect_ev(input string n, input logic [3:0] c, input int lo, input int hi, input bit rel = 1'b0);
        ev_t e;
        e.c = c; e.lo = lo; e.hi = hi; e.rel = rel;
        evq.push_back(e);
        evn.push_back(n);
    endtask

    task automatic expect_sn(input string n, input int at, input int sel, input int ch, input int val, input bit ge = 1'b0);
        sn_t s;
        int i;
        s.at = at; s.sel = sel; s.ch = ch; s.val = val; s.ge = ge;
        i = snq.size();
        while (i > 0 && snq[i-1].at > at) i--;
        snq.insert(i, s);
        snn.insert(i, n);
    endtask

    function automatic int probe(input int sel, input int ch);
        case (sel)
            ET:  return int'(elapsed[ch*TW +: TW]);
            CNT: return int'(count[ch*CW +: CW]);
            QV:  return int'(q);
            TK:  return int'(tick);
            default: return int'(ctrl);
        endcase
    endfunction

    initial begin : monitor
        logic [3:0] prev;
        int last, lo, hi, act;
        ev_t e;
        sn_t s;
        string n;
        prev = '0;
        last = 0;
        forever begin
            @(posedge clk);
            #1;
            if (ctrl !== prev) begin
                checks++;
                if (evq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ctrl cyc=%0d got=%b was=%b", cyc, ctrl, prev);
                end else begin
                    e = evq.pop_front();
                    n = evn.pop_front();
                    lo = e.rel ? last + e.lo : e.lo;
                    hi = e.rel ? last + e.hi : e.hi;
                    if (ctrl !== e.c || cyc < lo || cyc > hi) begin
                        errors++;
                        $display("FAIL %s ctrl got=%b at cyc %0d, want=%b in [%0d,%0d]", n, ctrl, cyc, e.c, lo, hi);
                    end
                end
                prev = ctrl;
                last = cyc;
            end
            while (snq.size() > 0 && snq[0].at <= cyc) begin
                s = snq.pop_front();
                n = snn.pop_front();
                act = probe(s.sel, s.ch);
                checks++;
                if (s.at != cyc || (s.ge ? act < s.val : act != s.val)) begin
                    errors++;
                    $display("FAIL %s cyc=%0d got=%0d want=%s%0d", n, s.at, act, s.ge ? ">=" : "", s.val);
                end
            end
        end
    end

    initial begin : stim
        int c, s, r;
        tpreset = {4{8'd3}};
        cpreset = {4'd15, 4'd3, 4'd15, 4'd15};
        step(2);
        rst = 1'b0;
        r = cyc;
        expect_sn("rst_ctrl", r+1, 4, 0, 0);
        expect_sn("rst_q", r+1, QV, 0, 0);
        expect_sn("rst_et", r+1, ET, 0, 0);
        expect_sn("rst_cnt", r+1, CNT, 2, 0);
        expect_sn("tick_lo", r+2, TK, 0, 0);
        expect_sn("tick_hi", r+3, TK, 0, 1);
        expect_sn("tick_lo2", r+4, TK, 0, 0);
        expect_sn("tick_hi2", r+7, TK, 0, 1);
        step(4);
        // TON, PT=3
        c = cyc; start[0] = 1'b1;
        expect_ev("ton_rise", 4'b0001, c+12, c+15);
        step(1); start[0] = 1'b0;
        step(19); s = cyc; stop[0] = 1'b1;
        expect_sn("ton_et_hold", s+1, ET, 0, 3);
        expect_ev("ton_fall", 4'b0000, s+2, s+2);
        expect_sn("ton_et_clr", s+2, ET, 0, 0);
        expect_sn("ton_count", s+2, CNT, 0, 1);
        step(1); stop[0] = 1'b0;
        step(3);
        // TOF, PT=3
        mode[1:0] = 2'b01;
        c = cyc; start[0] = 1'b1;
        expect_ev("tof_on", 4'b0001, c+2, c+2);
        step(1); start[0] = 1'b0;
        step(4); s = cyc; stop[0] = 1'b1;
        expect_ev("tof_off", 4'b0000, s+12, s+15);
        step(1); stop[0] = 1'b0;
        step(19);
        c = cyc; start[0] = 1'b1;
        expect_ev("tof_on2", 4'b0001, c+2, c+2);
        step(1); start[0] = 1'b0;
        step(3); s = cyc; stop[0] = 1'b1;
        step(1); stop[0] = 1'b0;
        step(7); start[0] = 1'b1;
        expect_sn("tof_et_run", s+9, ET, 0, 1, 1'b1);
        expect_sn("tof_et_restart", s+10, ET, 0, 0);
        step(1); start[0] = 1'b0;
        step(5); s = cyc; stop[0] = 1'b1;
        expect_ev("tof_off2", 4'b0000, s+12, s+15);
        expect_sn("tof_count", s+20, CNT, 0, 3);
        step(1); stop[0] = 1'b0;
        step(21);
        // TP, PT=2: one pulse per latch set, not abortable by stop
        mode[3:2] = 2'b10;
        tpreset[15:8] = 8'd2;
        c = cyc; start[1] = 1'b1;
        expect_ev("tp_on", 4'b0010, c+2, c+2);
        expect_ev("tp_off", 4'b0000, 6, 9, 1'b1);
        step(1); start[1] = 1'b0;
        step(80); stop[1] = 1'b1;
        step(1); stop[1] = 1'b0;
        step(2); c = cyc; start[1] = 1'b1;
        expect_ev("tp_on2", 4'b0010, c+2, c+2);
        expect_ev("tp_off2", 4'b0000, 6, 9, 1'b1);
        step(1); start[1] = 1'b0;
        step(2); stop[1] = 1'b1;
        step(1); stop[1] = 1'b0;
        step(20);
        // counter on ch2: CP=3, TON with PT=0
        tpreset[23:16] = 8'd0;
        for (int i = 0; i < 17; i++) begin
            c = cyc; start[2] = 1'b1;
            expect_ev("cnt_rise", 4'b0100, c+3, c+3);
            expect_sn("cnt_val", c+4, CNT, 2, (i + 1 > 15) ? 15 : i + 1);
            expect_sn("cnt_q", c+4, QV, 0, (i >= 2) ? 4 : 0);
            expect_ev("cnt_fall", 4'b0000, c+6, c+6);
            step(1); start[2] = 1'b0;
            step(3); stop[2] = 1'b1;
            step(1); stop[2] = 1'b0;
            step(2);
        end
        c = cyc; start[2] = 1'b1;
        expect_ev("clr_rise", 4'b0100, c+3, c+3);
        expect_sn("clr_cnt", c+4, CNT, 2, 0);
        expect_sn("clr_q", c+4, QV, 0, 0);
        expect_sn("clr_hold", c+6, CNT, 2, 0);
        expect_ev("clr_fall", 4'b0000, c+6, c+6);
        step(1); start[2] = 1'b0;
        step(2); cnt_clr[2] = 1'b1;
        step(1); cnt_clr[2] = 1'b0; stop[2] = 1'b1;
        step(1); stop[2] = 1'b0;
        step(3);
        // start+stop together sets the latch; then async reset mid-run
        c = cyc; start[3] = 1'b1; stop[3] = 1'b1;
        expect_ev("ss_rise", 4'b1000, c+12, c+15);
        step(1); start[3] = 1'b0; stop[3] = 1'b0;
        step(19);
        mode = '0;
        tpreset[23:0] = {3{8'd10}};
        c = cyc; start = 4'b0111;
        step(1); start = '0;
        step(14);
        expect_sn("pre_rst_et", c+16, ET, 0, 2, 1'b1);
        step(1);
        #1 rst = 1'b1;
        #2 rst = 1'b0;
        expect_ev("rst_ctrl_clr", 4'b0000, c+17, c+17);
        for (int i = 0; i < N; i++) begin
            expect_sn("rst_et_clr", c+17, ET, i, 0);
            expect_sn("rst_cnt_clr", c+17, CNT, i, 0);
        end
        expect_sn("rst_q_clr", c+17, QV, 0, 0);
        step(2);
        // MAN path and no-selector path
        c = cyc; auto_mode = 1'b0; man_mode = 1'b1; start = 4'b0101;
        expect_ev("man_on", 4'b0101, c+1, c+1);
        step(1); start = '0;
        expect_ev("man_off", 4'b0000, c+2, c+2);
        step(2); start = 4'b1010;
        expect_ev("man_on2", 4'b1010, c+4, c+4);
        step(2); man_mode = 1'b0;
        expect_ev("no_sel", 4'b0000, c+6, c+6);
        step(1); start = '0; stop = 4'hf;
        step(1); stop = '0;
        step(3);
        // TON with PT=0 on ch1
        auto_mode = 1'b1;
        tpreset[15:8] = 8'd0;
        c = cyc; start[1] = 1'b1;
        expect_ev("pt0_rise", 4'b0010, c+3, c+3);
        step(1); start[1] = 1'b0;
        step(4); stop[1] = 1'b1;
        expect_ev("pt0_fall", 4'b0000, c+7, c+7);
        step(1); stop[1] = 1'b0;
        step(10);
        while (evq.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s ctrl change to %b never seen", evn[0], evq[0].c);
            void'(evq.pop_front());
            void'(evn.pop_front());
        end
        while (snq.size() > 0) begin
            checks++; errors++;
            $display("FAIL %s snapshot at cyc %0d never taken", snn[0], snq[0].at);
            void'(snq.pop_front());
            void'(snn.pop_front());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
